// File: rtl/id_stage_pkg.sv
// Shared pipeline types for the decode stage: IF/ID and ID/EX records,
// control enums, RV32I opcode constants.
package id_stage_pkg;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSN_ECALL  = 32'h00000073;
    localparam logic [31:0] INSN_EBREAK = 32'h00100073;

    typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} alu_src_a_e;
    typedef enum logic {SRCB_RS2, SRCB_IMM} alu_src_b_e;
    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_e;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
        logic        jalr;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        result_src_e result_src;
        alu_op_e     alu_op;
        logic [2:0]  funct3;
        logic        illegal;
        logic        ecall;
        logic        ebreak;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '0;

    // alt selects SUB/SRA; callers only pass it where funct7[5] is meaningful
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Register-file write bus driven by writeback.
interface id_stage_if;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;

    modport master (output we, rd, data);
    modport slave  (input  we, rd, data);
endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two combinational read ports with same-cycle write
// bypass, one synchronous write port. x0 is hardwired to zero.
module id_stage_regfile (
    input  logic        clk,
    id_stage_if.slave   wr,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] mem [32];

    always_ff @(posedge clk) begin
        if (wr.we && wr.rd != 5'd0) mem[wr.rd] <= wr.data;
    end

    // raddr != 0 is checked first, so a bypass hit can never target x0
    always_comb begin
        if (raddr1 == 5'd0)                    rdata1 = '0;
        else if (wr.we && wr.rd == raddr1)     rdata1 = wr.data;
        else                                   rdata1 = mem[raddr1];
        if (raddr2 == 5'd0)                    rdata2 = '0;
        else if (wr.we && wr.rd == raddr2)     rdata2 = wr.data;
        else                                   rdata2 = mem[raddr2];
    end
endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: aligns PC with the BRAM instruction word, decodes,
// reads the register file and registers the result into ID/EX.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr,
    input  if_id_t      in,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output id_ex_t      out,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr
);
    logic [31:0] pc_q, pcplus4_q;
    logic        fv_q;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opcode;
    id_ex_t      dec;

    id_stage_if wb_if ();
    assign wb_if.we   = wb_we;
    assign wb_if.rd   = wb_rd;
    assign wb_if.data = wb_data;

    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign opcode   = instr[6:0];

    id_stage_regfile u_regfile (
        .clk    (clk),
        .wr     (wb_if),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // instr arrives one cycle after its PC, so the PC is delayed to match;
    // fv_q marks the first BRAM word after reset/redirect as garbage
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            pcplus4_q <= '0;
            fv_q      <= 1'b0;
        end else begin
            if (flush)       fv_q <= 1'b0;
            else if (!stall) fv_q <= 1'b1;
            if (!stall && !flush) begin
                pc_q      <= in.pc;
                pcplus4_q <= in.pcplus4;
            end
        end
    end

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        dec.valid    = fv_q;
        dec.pc       = pc_q;
        dec.pcplus4  = pcplus4_q;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.rd       = instr[11:7];
        dec.rs1      = rs1_addr;
        dec.rs2      = rs2_addr;
        dec.funct3   = instr[14:12];
        case (opcode)
            OPC_LUI: begin
                dec.imm = imm_u; dec.reg_we = 1'b1;
                dec.alu_src_a = SRCA_ZERO; dec.alu_src_b = SRCB_IMM;
            end
            OPC_AUIPC: begin
                dec.imm = imm_u; dec.reg_we = 1'b1;
                dec.alu_src_a = SRCA_PC; dec.alu_src_b = SRCB_IMM;
            end
            OPC_JAL: begin
                dec.imm = imm_j; dec.reg_we = 1'b1; dec.jump = 1'b1;
                dec.alu_src_a = SRCA_PC; dec.alu_src_b = SRCB_IMM; dec.result_src = RES_PC4;
            end
            OPC_JALR: begin
                dec.imm = imm_i; dec.reg_we = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
                dec.alu_src_b = SRCB_IMM; dec.result_src = RES_PC4;
            end
            OPC_BRANCH: begin
                dec.imm = imm_b; dec.branch = 1'b1;
                dec.alu_op = instr[14] ? (instr[13] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            OPC_LOAD: begin
                dec.imm = imm_i; dec.reg_we = 1'b1; dec.mem_re = 1'b1;
                dec.alu_src_b = SRCB_IMM; dec.result_src = RES_MEM;
            end
            OPC_STORE: begin
                dec.imm = imm_s; dec.mem_we = 1'b1; dec.alu_src_b = SRCB_IMM;
            end
            OPC_OPIMM: begin
                dec.imm = imm_i; dec.reg_we = 1'b1; dec.alu_src_b = SRCB_IMM;
                dec.alu_op = arith_op(instr[14:12], instr[14:12] == 3'b101 && instr[30]);
            end
            OPC_OP: begin
                dec.reg_we = 1'b1;
                dec.alu_op = arith_op(instr[14:12], instr[30]);
            end
            OPC_FENCE: ;
            OPC_SYSTEM: begin
                if (instr == INSN_ECALL)       dec.ecall   = 1'b1;
                else if (instr == INSN_EBREAK) dec.ebreak  = 1'b1;
                else                           dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.rd == 5'd0) dec.reg_we = 1'b0;
        // a squashed word must not write, trap or redirect downstream
        if (!fv_q) begin
            dec.reg_we  = 1'b0; dec.mem_re = 1'b0; dec.mem_we = 1'b0;
            dec.branch  = 1'b0; dec.jump   = 1'b0; dec.jalr   = 1'b0;
            dec.illegal = 1'b0; dec.ecall  = 1'b0; dec.ebreak = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush || stall) out <= BUBBLE;
        else                       out <= dec;
    end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: stimulus pushes one expected ID/EX record per
// edge, a monitor pops and compares after each rising edge.
module tb_id_stage;
    import id_stage_pkg::*;

    typedef struct {
        string       tag;
        int          mode;  // 0: valid/illegal only, 1: fields, 2: fields + rs data
        logic [6:0]  ctl;   // {valid, reg_we, mem_we, branch, jump, src_b_imm, illegal}
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    localparam logic [6:0] C_I   = 7'b1100010;
    localparam logic [6:0] C_R   = 7'b1100000;
    localparam logic [6:0] C_B   = 7'b1001000;
    localparam logic [6:0] C_S   = 7'b1010010;
    localparam logic [6:0] C_J   = 7'b1100110;
    localparam logic [6:0] C_ILL = 7'b1000001;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] instr;
    if_id_t      in_s;
    id_ex_t      out_s;
    logic [4:0]  rs1_addr, rs2_addr;
    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    id_stage_if wbb ();

    id_stage dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .instr    (instr),
        .in       (in_s),
        .wb_we    (wbb.we),
        .wb_rd    (wbb.rd),
        .wb_data  (wbb.data),
        .out      (out_s),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string tag, input int mode, input logic [6:0] ctl,
                                input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] imm,
                                input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        e.tag = tag; e.mode = mode; e.ctl = ctl; e.pc = pc;
        e.rd = rd; e.imm = imm; e.r1 = r1; e.r2 = r2;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic fl,
                        input logic [31:0] ins, input logic [31:0] pcin,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                        input exp_t e);
        @(negedge clk);
        rst = r; stall = st; flush = fl; instr = ins;
        in_s.pc = pcin; in_s.pcplus4 = pcin + 32'd4;
        wbb.we = we; wbb.rd = wrd; wbb.data = wd;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [6:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {out_s.valid, out_s.reg_we, out_s.mem_we, out_s.branch, out_s.jump,
                     out_s.alu_src_b == SRCB_IMM, out_s.illegal};
                if (e.mode == 0) begin
                    chk({e.tag, ".valid_illegal"}, {30'b0, a[6], a[0]}, {30'b0, e.ctl[6], e.ctl[0]});
                end else begin
                    chk({e.tag, ".ctl"}, {25'b0, a}, {25'b0, e.ctl});
                    chk({e.tag, ".pc"},  out_s.pc, e.pc);
                    chk({e.tag, ".rd"},  {27'b0, out_s.rd}, {27'b0, e.rd});
                    chk({e.tag, ".imm"}, out_s.imm, e.imm);
                    if (e.mode == 2) begin
                        chk({e.tag, ".rs1_data"}, out_s.rs1_data, e.r1);
                        chk({e.tag, ".rs2_data"}, out_s.rs2_data, e.r2);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; instr = NOP;
        in_s = '0; wbb.we = 1'b0; wbb.rd = '0; wbb.data = '0;

        step(1, 0, 0, 32'h00500093, 32'h00, 0, 0, 0, mk("rst",      2, 7'b0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 32'h00500093, 32'h10, 0, 0, 0, mk("rst_sq",   0, 7'b0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 32'h00500093, 32'h14, 1, 1, 32'h11111111,
             mk("addi", 1, C_I, 32'h10, 1, 32'd5, 0, 0));
        step(0, 0, 1, 32'h00A00113, 32'h18, 0, 0, 0, mk("flush",    2, 7'b0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 32'hFFF00213, 32'h40, 0, 0, 0, mk("flush_sq", 0, 7'b0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 32'h123452B7, 32'h44, 0, 0, 0,
             mk("lui", 1, C_I, 32'h40, 5, 32'h12345000, 0, 0));
        step(0, 0, 0, 32'h002081B3, 32'h48, 1, 2, 32'hDEADBEEF,
             mk("add_bypass", 2, C_R, 32'h44, 3, 0, 32'h11111111, 32'hDEADBEEF));
        #1;
        chk("rs1_addr", {27'b0, rs1_addr}, 32'd1);
        chk("rs2_addr", {27'b0, rs2_addr}, 32'd2);
        step(0, 0, 0, 32'h000001B3, 32'h4C, 1, 0, 32'hCAFEF00D,
             mk("x0_write", 2, C_R, 32'h48, 3, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 32'hFE208CE3, 32'h50, 0, 0, 0, mk("stall", 2, 7'b0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 32'hFE208CE3, 32'h50, 0, 0, 0,
             mk("beq", 2, C_B, 32'h4C, 25, 32'hFFFFFFF8, 32'h11111111, 32'hDEADBEEF));
        step(0, 0, 0, 32'h0020A623, 32'h54, 0, 0, 0,
             mk("sw", 2, C_S, 32'h50, 12, 32'd12, 32'h11111111, 32'hDEADBEEF));
        step(0, 0, 0, 32'h010000EF, 32'h58, 0, 0, 0,
             mk("jal", 1, C_J, 32'h54, 1, 32'd16, 0, 0));
        step(0, 0, 0, 32'hFFFFFFFF, 32'h5C, 0, 0, 0,
             mk("illegal", 1, C_ILL, 32'h58, 31, 0, 0, 0));
        step(0, 1, 1, 32'h00500093, 32'h60, 0, 0, 0, mk("flush_stall", 2, 7'b0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 32'hFFFFFFFF, 32'h80, 0, 0, 0, mk("sq_illegal",  0, 7'b0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 32'h00500093, 32'h84, 0, 0, 0,
             mk("redirect", 1, C_I, 32'h80, 1, 32'd5, 0, 0));
        step(1, 1, 0, 32'h00A00113, 32'h88, 0, 0, 0, mk("rst_stall", 2, 7'b0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 32'h00A00113, 32'h100, 0, 0, 0, mk("rst_sq2",  0, 7'b0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 32'hFFF00213, 32'h104, 0, 0, 0,
             mk("addi_neg", 1, C_I, 32'h100, 4, 32'hFFFFFFFF, 0, 0));

        @(negedge clk);
        @(negedge clk);
        chk("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
